// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - time-step counter feeding the one-hot step decoder
// Latches the instruction word on Run and handles Stall, Last, wrap overrun and Clear.
module step_sequencer #(
    parameter int NSTEPS = 11,
    parameter int IR_W   = 9
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic            Run,
    input  logic [IR_W-1:0] Din,
    input  logic            Stall,
    input  logic            Last,
    input  logic            Clear,
    output logic [3:0]      count,
    output logic [IR_W-1:0] IR,
    output logic            Busy,
    output logic            Done,
    output logic            Overrun
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MAX_STEP = 4'(NSTEPS - 1);

    state_t          state_q;
    logic [3:0]      count_q;
    logic [IR_W-1:0] ir_q;
    logic            busy_q;
    logic            done_q;
    logic            overrun_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            count_q   <= 4'd0;
            ir_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // Done is a single-cycle pulse; only an accepted Last re-arms it.
            done_q <= 1'b0;
            if (Clear) begin
                state_q   <= S_IDLE;
                count_q   <= 4'd0;
                busy_q    <= 1'b0;
                overrun_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (Run) begin
                            ir_q    <= Din;
                            count_q <= 4'd1;
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (!Stall) begin
                            if (Last) begin
                                count_q <= 4'd0;
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else if (count_q == MAX_STEP) begin
                                count_q   <= 4'd0;
                                state_q   <= S_IDLE;
                                busy_q    <= 1'b0;
                                overrun_q <= 1'b1;
                            end else begin
                                count_q <= count_q + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        count_q <= 4'd0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign count   = count_q;
    assign IR      = ir_q;
    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Overrun = overrun_q;

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Sequential time-step generator for the simple processor's control path. It sits directly upstream of the one-hot step decoder and drives its 4-bit count input, so the decoder emits time steps T0..T10. It also latches the instruction word at the start of each instruction, and handles stall, early-finish, abort and overrun.

Parameters:
NSTEPS, 11, number of decodable time steps; the highest legal count is NSTEPS-1 (10); must be 2..16.
IR_W, 9, instruction word width.

Ports:
Clock  in  1  system clock; all state changes on rising edge
Resetn  in  1  asynchronous, active-low reset
Run  in  1  start request; sampled only in IDLE
Din  in  IR_W  instruction word; captured into IR when Run is accepted
Stall  in  1  hold the current step (e.g. memory wait)
Last  in  1  from control logic: the current step is the final step of this instruction
Clear  in  1  synchronous abort; returns the block to IDLE
count  out  4  current time step, fed to the step decoder
IR  out  IR_W  latched instruction register
Busy  out  1  high while an instruction is executing (state RUN)
Done  out  1  one-cycle pulse after an instruction completes normally
Overrun  out  1  sticky error flag: the step count exceeded NSTEPS-1

Behaviour:
- Reset (Resetn=0, asynchronous): state=IDLE, count=0, IR=0, Busy=0, Done=0, Overrun=0. Every output is registered.
- States:
  - IDLE: count holds 0, so the decoder shows T0.
  - RUN: instruction in progress.
- Priority within a cycle: Resetn > Clear > Stall > Last > count wrap > increment.
- IDLE with Run=1:
  - IR<=Din, count<=1, state<=RUN.
  - Busy=1 from the next cycle.
  - Latency from Run to count=1 is one clock.
- IDLE with Run=0: nothing changes.
- RUN with Stall=1: count, IR and state hold. Last is ignored that cycle.
- RUN with Stall=0, Last=1:
  - count<=0, state<=IDLE, Done<=1 for exactly one cycle.
  - Busy drops in the same edge.
- RUN with Stall=0, Last=0, count<NSTEPS-1: count<=count+1.
- RUN with Stall=0, Last=0, count==NSTEPS-1 (wrap boundary):
  - count<=0, state<=IDLE, Overrun<=1.
  - Done stays 0.
- Run while in RUN: ignored. No queuing; IR is not overwritten.
- Run during the Done-pulse cycle: the block is in IDLE, so Run is accepted normally. This gives back-to-back instructions with count sequence ...,k,0,1,...
- Clear=1 (either state):
  - count<=0, state<=IDLE, Done<=0, Overrun<=0.
  - IR holds its value.
  - Clear beats a simultaneous Run and a simultaneous Last.
- Reset mid-instruction: immediate return to the reset values, with no Done.
- Done is 0 in every cycle except the single cycle after a Last is accepted.
- Overrun stays set until Clear or reset. A new Run is still accepted while Overrun=1.
- count never takes a value above NSTEPS-1.

Test Plan:
1. Reset then idle: Resetn pulse low, Run=0 for 5 clocks -> count=0, Busy=0, Done=0, IR=0 throughout.
2. Normal instruction: Din=9'h0A5 with Run for 1 cycle; Last asserted at count=3 -> IR=0A5, count sequence 1,2,3,0; Busy high for 3 cycles; Done high for exactly 1 cycle after count=3.
3. Stall: during RUN at count=2, hold Stall=1 for 3 cycles with Last=1 also asserted -> count stays 2 for 3 cycles; Last only takes effect after Stall drops; Done once.
4. Overrun: Run, then never assert Last -> count 1..10, then 0; Overrun=1 and stays high; Done never pulses; a following Run is still accepted with Overrun still 1; Clear then drops Overrun.
5. Back-to-back and ignored Run: Run held high continuously with Din changing every cycle; Last at count=2 -> IR updates only on cycles where the block is in IDLE; pattern repeats 1,2,0,1,2,0.
6. Abort and async reset: Clear at count=5 together with Run=1 -> count=0, IDLE, no Done, IR unchanged; then drop Resetn mid-instruction between clock edges -> outputs go to reset values immediately, without waiting for an edge.
